usb_hid_out_receiver: RTL and testbench
=======================================

// Module: usb_hid_out_receiver
// PURPOSE
//  HID OUT-endpoint receiver: host-to-device counterpart of the HID IN report transmitter.
//  Takes the byte stream of one OUT data packet from the USB packet engine and buffers it in a shadow register.
//  Checks the report ID, length and data toggle, then returns ACK/NAK/STALL to the packet engine.
//  Commits valid, non-duplicate reports (e.g. host volume/mute set) to the application side.
// PARAMETERS
//  REPORT_ID     8'h02  expected first byte of every OUT report
//  REPORT_BYTES  2      payload bytes following the ID; legal range 1..8
// PORTS
//  Clk            in   1   system clock; single clock domain
//  nReset         in   1   reset, asynchronous, active-low
//  Error          in   1   packet engine error (CRC/bit-stuff/timeout) for the current packet
//  OUT_Start      in   1   1-cycle pulse: DATAx PID received; OUT_Sequence valid this cycle
//  OUT_Sequence   in   1   PID toggle of the packet (0=DATA0, 1=DATA1)
//  OUT_Data       in   8   payload byte
//  OUT_Valid      in   1   OUT_Data valid this cycle
//  OUT_End        in   1   1-cycle pulse: packet complete, CRC good
//  OUT_Ack        out  1   1-cycle pulse: send ACK
//  OUT_Nak        out  1   1-cycle pulse: send NAK
//  OUT_Stall      out  1   1-cycle pulse: send STALL
//  Clear_Toggle   in   1   SET_CONFIGURATION/CLEAR_FEATURE: force expected toggle to 0
//  Report_Busy    in   1   application cannot accept a new report
//  Report         out  8*REPORT_BYTES  last committed payload; byte 0 in bits [7:0]
//  Report_Update  out  1   1-cycle pulse: Report just changed
// BEHAVIOUR
//  Reset (nReset=0, async): State=Idle, ExpSeq=0, Report=0, all pulse outputs 0, ByteCount=0, flags clear.
//  States: Idle, Receive, Respond.
//  Idle: on OUT_Start -> Receive; latch Seq=OUT_Sequence; clear ByteCount, BadId, Overflow.
//  Receive, per OUT_Valid byte:
//   - ByteCount==0: BadId set if byte != REPORT_ID.
//   - 1..REPORT_BYTES: stored in Shadow[ByteCount-1].
//   - further bytes: Overflow set, byte dropped.
//   - ByteCount saturates at REPORT_BYTES+1.
//  Receive, Error=1 (any cycle, including with OUT_End) -> Idle; no handshake, no commit, no toggle change.
//  Receive, OUT_End (Error=0) -> Respond; a byte with OUT_Valid in the same cycle is counted first.
//  Respond (exactly one cycle; handshake pulse 1 cycle after OUT_End), priority order:
//   1 BadId | Overflow | ByteCount != REPORT_BYTES+1 -> OUT_Stall; no commit, toggle unchanged.
//   2 Report_Busy=1 -> OUT_Nak; no commit, toggle unchanged (host retries same toggle).
//   3 Seq != ExpSeq -> OUT_Ack only (duplicate after lost ACK); no commit.
//   4 else -> OUT_Ack; Report<=Shadow; Report_Update=1 (same cycle); ExpSeq<=~ExpSeq.
//   Respond then -> Idle.
//  OUT_Start while in Receive: abort current packet silently and restart (new Seq, counters cleared).
//  OUT_Start in Respond: ignored (engine guarantees >=2 idle cycles between packets).
//  Clear_Toggle: ExpSeq<=0 any state; if coincident with a step-4 commit, Clear_Toggle wins.
//  At most one of OUT_Ack/OUT_Nak/OUT_Stall is high in any cycle.
//  Report holds its value between commits; Report_Busy is sampled only in Respond.
// STRUCTURE
//  Shared package usb_hid_pkg: state encoding, handshake enum (ACK/NAK/STALL); REPORT_ID defaults.
//  Single flat module; no sub-module (shadow buffer is a REPORT_BYTES x 8 register array).
// TESTING
//  1 Reset; Start(seq0), bytes 02 10 01, End -> OUT_Ack at End+1; Report=16'h0110; Update pulse; ExpSeq=1.
//  2 Repeat packet with seq0 -> OUT_Ack, no Update, Report unchanged, ExpSeq stays 1.
//  3 Seq1 packet 02 20 00 with Report_Busy=1 -> OUT_Nak, no commit.
//    Resend with Busy=0 -> Ack, Report=16'h0020.
//  4 Bytes 03 10 01 -> OUT_Stall.
//    Bytes 02 10 -> OUT_Stall.
//    Bytes 02 10 01 05 -> OUT_Stall.
//    In all three cases Report and ExpSeq are unchanged.
//  5 Error during the 2nd byte, and Error coincident with End -> no handshake pulse, state Idle next cycle.
//  6 nReset low mid-packet -> all outputs 0 asynchronously.
//    Clear_Toggle with ExpSeq=1, then seq0 packet -> commits.

Source files
------------

// File: rtl/usb_hid_pkg.sv
// Shared definitions for the HID OUT-endpoint receiver: FSM states, handshake codes and
// default report framing.
package usb_hid_pkg;

    localparam logic [7:0] HID_REPORT_ID_DEFAULT    = 8'h02;
    localparam int         HID_REPORT_BYTES_DEFAULT = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        HS_NONE  = 2'd0,
        HS_ACK   = 2'd1,
        HS_NAK   = 2'd2,
        HS_STALL = 2'd3
    } hs_e;

    // A malformed report always stalls, even if the application is busy.
    function automatic hs_e hs_select(input logic malformed, input logic busy);
        if (malformed) return HS_STALL;
        else if (busy) return HS_NAK;
        else           return HS_ACK;
    endfunction

endpackage

// File: rtl/usb_hid_out_receiver.sv
// HID OUT-endpoint receiver: buffers one OUT data packet, validates ID/length/toggle,
// answers ACK/NAK/STALL and commits fresh reports to the application.
module usb_hid_out_receiver
    import usb_hid_pkg::*;
#(
    parameter logic [7:0] REPORT_ID    = HID_REPORT_ID_DEFAULT,
    parameter int         REPORT_BYTES = HID_REPORT_BYTES_DEFAULT
) (
    input  logic                      Clk,
    input  logic                      nReset,
    input  logic                      Error,
    input  logic                      OUT_Start,
    input  logic                      OUT_Sequence,
    input  logic [7:0]                OUT_Data,
    input  logic                      OUT_Valid,
    input  logic                      OUT_End,
    output logic                      OUT_Ack,
    output logic                      OUT_Nak,
    output logic                      OUT_Stall,
    input  logic                      Clear_Toggle,
    input  logic                      Report_Busy,
    output logic [8*REPORT_BYTES-1:0] Report,
    output logic                      Report_Update
);

    localparam int               CNT_W    = $clog2(REPORT_BYTES + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(REPORT_BYTES + 1);

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic                      r_seq;
    logic                      r_exp_seq;
    logic                      r_bad_id;
    logic                      r_overflow;
    logic [CNT_W-1:0]          r_byte_cnt;
    logic [7:0]                r_shadow [REPORT_BYTES];
    logic [8*REPORT_BYTES-1:0] r_report;
    logic [8*REPORT_BYTES-1:0] w_shadow_flat;
    logic                      w_restart;
    logic                      w_take_byte;
    logic                      w_malformed;
    logic                      w_commit;
    hs_e                       w_hs;

    // An Error in Receive always wins over a coincident Start, End or data byte.
    assign w_restart   = OUT_Start && ((r_state == ST_IDLE) ||
                                       (r_state == ST_RECEIVE && !Error));
    assign w_take_byte = (r_state == ST_RECEIVE) && !Error && !OUT_Start && OUT_Valid;
    assign w_malformed = r_bad_id || r_overflow || (r_byte_cnt != CNT_FULL);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (OUT_Start) w_state_nxt = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                if (Error)          w_state_nxt = ST_IDLE;
                else if (OUT_Start) w_state_nxt = ST_RECEIVE;
                else if (OUT_End)   w_state_nxt = ST_RESPOND;
            end
            ST_RESPOND: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_hs     = HS_NONE;
        w_commit = 1'b0;
        if (r_state == ST_RESPOND) begin
            w_hs     = hs_select(w_malformed, Report_Busy);
            w_commit = (w_hs == HS_ACK) && (r_seq == r_exp_seq);
        end
    end

    assign OUT_Ack       = (w_hs == HS_ACK);
    assign OUT_Nak       = (w_hs == HS_NAK);
    assign OUT_Stall     = (w_hs == HS_STALL);
    assign Report_Update = w_commit;
    assign Report        = r_report;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state    <= ST_IDLE;
            r_seq      <= 1'b0;
            r_exp_seq  <= 1'b0;
            r_bad_id   <= 1'b0;
            r_overflow <= 1'b0;
            r_byte_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_restart) begin
                r_seq      <= OUT_Sequence;
                r_byte_cnt <= '0;
                r_bad_id   <= 1'b0;
                r_overflow <= 1'b0;
            end else if (w_take_byte) begin
                if (r_byte_cnt == '0)
                    r_bad_id <= (OUT_Data != REPORT_ID);
                else if (r_byte_cnt == CNT_FULL)
                    r_overflow <= 1'b1;
                if (r_byte_cnt != CNT_FULL)
                    r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            if (Clear_Toggle)
                r_exp_seq <= 1'b0;
            else if (w_commit)
                r_exp_seq <= ~r_exp_seq;
        end
    end

    // Payload byte k (1-based after the ID) lands in shadow slot k-1.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < REPORT_BYTES; i++) begin
            if (w_take_byte && r_byte_cnt == CNT_W'(i + 1))
                r_shadow[i] <= OUT_Data;
        end
    end

    always_comb begin
        w_shadow_flat = '0;
        for (int i = 0; i < REPORT_BYTES; i++)
            w_shadow_flat[8*i +: 8] = r_shadow[i];
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)
            r_report <= '0;
        else if (w_commit)
            r_report <= w_shadow_flat;
    end

endmodule

// File: tb/tb_usb_hid_out_receiver.sv
// Randomized packet-level bench for usb_hid_out_receiver with a report/toggle reference model.
module tb_usb_hid_out_receiver;

    localparam logic [7:0] ID = 8'h02;
    localparam int         RB = 2;

    typedef logic [7:0] bq_t [$];

    logic              Clk = 1'b0;
    logic              nReset = 1'b0;
    logic              Error = 1'b0;
    logic              OUT_Start = 1'b0;
    logic              OUT_Sequence = 1'b0;
    logic [7:0]        OUT_Data = 8'h00;
    logic              OUT_Valid = 1'b0;
    logic              OUT_End = 1'b0;
    logic              OUT_Ack;
    logic              OUT_Nak;
    logic              OUT_Stall;
    logic              Clear_Toggle = 1'b0;
    logic              Report_Busy = 1'b0;
    logic [8*RB-1:0]   Report;
    logic              Report_Update;

    int                n_checks = 0;
    int                n_fail   = 0;
    logic              m_exp    = 1'b0;
    logic [8*RB-1:0]   m_report = '0;
    bq_t               q;

    usb_hid_out_receiver #(.REPORT_ID(ID), .REPORT_BYTES(RB)) dut (
        .Clk(Clk), .nReset(nReset), .Error(Error), .OUT_Start(OUT_Start),
        .OUT_Sequence(OUT_Sequence), .OUT_Data(OUT_Data), .OUT_Valid(OUT_Valid),
        .OUT_End(OUT_End), .OUT_Ack(OUT_Ack), .OUT_Nak(OUT_Nak), .OUT_Stall(OUT_Stall),
        .Clear_Toggle(Clear_Toggle), .Report_Busy(Report_Busy), .Report(Report),
        .Report_Update(Report_Update)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pulses"}, {OUT_Ack, OUT_Nak, OUT_Stall, Report_Update}, 4'b0000);
    endtask

    // One OUT transaction plus its handshake, checked against the packet-level model.
    // err_mode: 0 none, 1 Error on 2nd byte, 2 Error with End.
    task automatic send_pkt(input logic seq, input bq_t bytes, input logic busy,
                            input int err_mode, input int abort_pre, input logic end_last,
                            input logic clr_resp, input string tag);
        int              n;
        logic            aborted;
        logic            good;
        logic            e_ack, e_nak, e_stall, e_upd;
        logic [8*RB-1:0] payload;
        n       = bytes.size();
        aborted = 1'b0;
        Report_Busy = busy;
        if (abort_pre > 0) begin
            OUT_Start = 1'b1; OUT_Sequence = 1'($urandom); tick(); OUT_Start = 1'b0;
            for (int k = 0; k < abort_pre; k++) begin
                OUT_Valid = 1'b1; OUT_Data = 8'($urandom); tick();
            end
            OUT_Valid = 1'b0;
        end
        OUT_Start = 1'b1; OUT_Sequence = seq; tick(); OUT_Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            OUT_Valid = 1'b1; OUT_Data = bytes[i];
            if (err_mode == 1 && i == 1) Error = 1'b1;
            if (err_mode != 1 && end_last && i == n - 1) begin
                OUT_End = 1'b1; Error = (err_mode == 2);
            end
            tick();
            OUT_Valid = 1'b0; OUT_End = 1'b0;
            if (err_mode == 1 && i == 1) aborted = 1'b1;
            Error = 1'b0;
            if (aborted) break;
        end
        if (!aborted && !(end_last && n > 0)) begin
            OUT_End = 1'b1; Error = (err_mode == 2); tick(); OUT_End = 1'b0; Error = 1'b0;
        end
        if (clr_resp) Clear_Toggle = 1'b1;

        good    = (n == RB + 1) && (bytes[0] == ID);
        payload = '0;
        for (int i = 0; i < RB; i++)
            if (i + 1 < n) payload[8*i +: 8] = bytes[i+1];
        e_stall = (err_mode == 0) && !good;
        e_nak   = (err_mode == 0) && good && busy;
        e_ack   = (err_mode == 0) && good && !busy;
        e_upd   = e_ack && (seq == m_exp);

        @(negedge Clk);
        check({tag, "_ack"},   OUT_Ack,       e_ack);
        check({tag, "_nak"},   OUT_Nak,       e_nak);
        check({tag, "_stall"}, OUT_Stall,     e_stall);
        check({tag, "_upd"},   Report_Update, e_upd);
        tick();
        Clear_Toggle = 1'b0;
        if (e_upd) begin
            m_report = payload;
            m_exp    = ~m_exp;
        end
        if (clr_resp) m_exp = 1'b0;
        check({tag, "_report"}, Report, m_report);
        @(negedge Clk);
        check_quiet({tag, "_after"});
        tick();
        tick();
        Report_Busy = 1'b0;
    endtask

    task automatic clear_toggle();
        Clear_Toggle = 1'b1; tick(); Clear_Toggle = 1'b0; m_exp = 1'b0;
    endtask

    initial begin
        int   n, err, pre;
        logic seq;

        #3;
        check("reset_report", Report, '0);
        check_quiet("reset");
        tick();
        nReset = 1'b1;
        tick();

        send_pkt(1'b0, '{8'h02, 8'h10, 8'h01}, 1'b0, 0, 0, 1'b0, 1'b0, "t1_commit");
        check("t1_value", Report, 16'h0110);
        send_pkt(1'b0, '{8'h02, 8'h55, 8'h66}, 1'b0, 0, 0, 1'b1, 1'b0, "t2_dup");
        send_pkt(1'b1, '{8'h02, 8'h20, 8'h00}, 1'b1, 0, 0, 1'b0, 1'b0, "t3_nak");
        send_pkt(1'b1, '{8'h02, 8'h20, 8'h00}, 1'b0, 0, 0, 1'b1, 1'b0, "t3_ack");
        check("t3_value", Report, 16'h0020);
        send_pkt(1'b0, '{8'h03, 8'h10, 8'h01},        1'b0, 0, 0, 1'b0, 1'b0, "t4_badid");
        send_pkt(1'b0, '{8'h02, 8'h10},               1'b0, 0, 0, 1'b1, 1'b0, "t4_short");
        send_pkt(1'b0, '{8'h02, 8'h10, 8'h01, 8'h05}, 1'b1, 0, 0, 1'b1, 1'b0, "t4_long");
        send_pkt(1'b0, '{8'h02, 8'h77, 8'h88}, 1'b0, 1, 0, 1'b0, 1'b0, "t5_err_byte");
        send_pkt(1'b0, '{8'h02, 8'h77, 8'h88}, 1'b0, 2, 0, 1'b1, 1'b0, "t5_err_end");
        send_pkt(1'b0, '{8'h02, 8'h34, 8'h12}, 1'b0, 0, 2, 1'b0, 1'b1, "clr_commit");
        check("clr_commit_value", Report, 16'h1234);
        send_pkt(1'b0, '{8'h02, 8'hAB, 8'hCD}, 1'b0, 0, 0, 1'b0, 1'b0, "clr_won");

        // Asynchronous reset mid-packet, away from any clock edge.
        OUT_Start = 1'b1; OUT_Sequence = 1'b1; tick(); OUT_Start = 1'b0;
        OUT_Valid = 1'b1; OUT_Data = ID; tick(); OUT_Valid = 1'b0;
        #2 nReset = 1'b0;
        #1;
        check("t6_async_report", Report, '0);
        check_quiet("t6_async");
        m_report = '0; m_exp = 1'b0;
        tick(); tick();
        nReset = 1'b1;
        tick();
        @(negedge Clk);
        check_quiet("t6_post");
        tick();

        send_pkt(1'b0, '{8'h02, 8'h0F, 8'hF0}, 1'b0, 0, 0, 1'b1, 1'b0, "t6_seq0");
        clear_toggle();
        tick();
        send_pkt(1'b0, '{8'h02, 8'h5A, 8'hA5}, 1'b0, 0, 0, 1'b0, 1'b0, "t6_after_clr");
        check("t6_value", Report, 16'hA55A);

        for (int it = 0; it < 60; it++) begin
            seq = 1'($urandom);
            n   = RB + 1;
            case ($urandom_range(0, 9))
                0: n = RB;
                1: n = RB + 2;
                2: n = 1;
                default: n = RB + 1;
            endcase
            q.delete();
            q.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom) : ID);
            for (int i = 1; i < n; i++) q.push_back(8'($urandom));
            err = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            if (err == 1 && n < 2) err = 2;
            pre = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
            if ($urandom_range(0, 11) == 0) clear_toggle();
            send_pkt(seq, q, ($urandom_range(0, 4) == 0), err, pre, 1'($urandom),
                     ($urandom_range(0, 9) == 0), $sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
